// File: rtl/keypad_entry_buffer_if.sv
// Keypad entry buffer bus: event pulses from the keyscan side, registered entry state back.
// master drives the key events, slave (the buffer) drives the entry state.
interface keypad_entry_buffer_if #(
    parameter int MAX_DIGITS = 8,
    parameter int CODE_W     = 4
);
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    logic                         key_valid;
    logic [CODE_W-1:0]            key_code;
    logic                         backspace;
    logic                         confirm;
    logic                         clear;
    logic [MAX_DIGITS*CODE_W-1:0] digits;
    logic [CNT_W-1:0]             count;
    logic                         full;
    logic                         locked;
    logic                         done;
    logic                         err;
    logic [1:0]                   err_code;

    modport master (
        output key_valid, key_code, backspace, confirm, clear,
        input  digits, count, full, locked, done, err, err_code
    );

    modport slave (
        input  key_valid, key_code, backspace, confirm, clear,
        output digits, count, full, locked, done, err, err_code
    );
endinterface

// File: rtl/keypad_entry_buffer.sv
// Digit-entry buffer with backspace/clear/confirm and a LOCKED state after confirm.
// One-edge latency, all outputs registered; never stalls, events in the wrong state are dropped.
module keypad_entry_buffer #(
    parameter int MAX_DIGITS = 8,
    parameter int CODE_W     = 4,
    parameter int MIN_DIGITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    keypad_entry_buffer_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int DIG_W = MAX_DIGITS * CODE_W;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_DIGITS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [1:0] ERR_OVERFLOW  = 2'd1;
    localparam logic [1:0] ERR_UNDERFLOW = 2'd2;
    localparam logic [1:0] ERR_SHORT     = 2'd3;

    typedef enum logic {
        ST_ENTRY  = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [DIG_W-1:0] digits_q, digits_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;

    logic ev_clear, ev_confirm, ev_back, ev_key, confirm_ok;

    // Only the highest-priority event of the cycle acts.
    assign ev_clear   = bus.clear;
    assign ev_confirm = bus.confirm & ~bus.clear;
    assign ev_back    = bus.backspace & ~bus.confirm & ~bus.clear;
    assign ev_key     = bus.key_valid & ~bus.backspace & ~bus.confirm & ~bus.clear;
    assign confirm_ok = (count_q >= CNT_MIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ENTRY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ENTRY: begin
                if (ev_confirm && confirm_ok) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (ev_clear) begin
                    state_d = ST_ENTRY;
                end
            end
            default: state_d = ST_ENTRY;
        endcase
    end

    always_comb begin
        digits_d   = digits_q;
        count_d    = count_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        if (ev_clear) begin
            digits_d = '0;
            count_d  = '0;
        end else if (state_q == ST_ENTRY) begin
            if (ev_confirm) begin
                if (confirm_ok) begin
                    done_d = 1'b1;
                end else begin
                    err_d      = 1'b1;
                    err_code_d = ERR_SHORT;
                end
            end else if (ev_back) begin
                if (count_q != '0) begin
                    count_d = count_q - CNT_ONE;
                    // Vacated slot is zeroed so slots beyond count always read 0.
                    for (int i = 0; i < MAX_DIGITS; i++) begin
                        if (CNT_W'(i) == count_d) begin
                            digits_d[i*CODE_W +: CODE_W] = '0;
                        end
                    end
                end else begin
                    err_d      = 1'b1;
                    err_code_d = ERR_UNDERFLOW;
                end
            end else if (ev_key) begin
                if (count_q != CNT_MAX) begin
                    count_d = count_q + CNT_ONE;
                    for (int i = 0; i < MAX_DIGITS; i++) begin
                        if (CNT_W'(i) == count_q) begin
                            digits_d[i*CODE_W +: CODE_W] = bus.key_code;
                        end
                    end
                end else begin
                    err_d      = 1'b1;
                    err_code_d = ERR_OVERFLOW;
                end
            end
        end
        full_d = (count_d == CNT_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            digits_q   <= digits_d;
            count_q    <= count_d;
            full_q     <= full_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign bus.digits   = digits_q;
    assign bus.count    = count_q;
    assign bus.full     = full_q;
    assign bus.locked   = (state_q == ST_LOCKED);
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.err_code = err_code_q;
endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Directed bench for keypad_entry_buffer (MAX_DIGITS=8, CODE_W=4, MIN_DIGITS=4).
module tb_keypad_entry_buffer;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   err_cnt;
    int   done_cnt;
    int   both_cnt;
    int   err_base;
    int   done_base;

    keypad_entry_buffer_if #(.MAX_DIGITS(8), .CODE_W(4)) kb_if ();

    keypad_entry_buffer #(
        .MAX_DIGITS(8),
        .CODE_W    (4),
        .MIN_DIGITS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(kb_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse counters, one sample per cycle away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (kb_if.err) err_cnt++;
            if (kb_if.done) done_cnt++;
            if (kb_if.err && kb_if.done) both_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of events; returns 1 time unit after the sampling edge.
    task automatic ev(input logic kv, input logic [3:0] code, input logic bs,
                      input logic cf, input logic cl);
        @(negedge clk);
        kb_if.key_valid = kv;
        kb_if.key_code  = code;
        kb_if.backspace = bs;
        kb_if.confirm   = cf;
        kb_if.clear     = cl;
        @(posedge clk);
        #1;
        kb_if.key_valid = 1'b0;
        kb_if.key_code  = 4'h0;
        kb_if.backspace = 1'b0;
        kb_if.confirm   = 1'b0;
        kb_if.clear     = 1'b0;
    endtask

    task automatic key(input logic [3:0] code);
        ev(1'b1, code, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        ev(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        err_cnt  = 0;
        done_cnt = 0;
        both_cnt = 0;
        kb_if.key_valid = 1'b0;
        kb_if.key_code  = 4'h0;
        kb_if.backspace = 1'b0;
        kb_if.confirm   = 1'b0;
        kb_if.clear     = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;

        check("rst digits", kb_if.digits, 32'h0);
        check("rst count", 32'(kb_if.count), 32'd0);
        check("rst full", 32'(kb_if.full), 32'd0);
        check("rst locked", 32'(kb_if.locked), 32'd0);
        check("rst done", 32'(kb_if.done), 32'd0);
        check("rst err", 32'(kb_if.err), 32'd0);
        check("rst err_code", 32'(kb_if.err_code), 32'd0);

        // 1: three keys
        key(4'h1);
        check("t1 count1", 32'(kb_if.count), 32'd1);
        key(4'h2);
        key(4'h3);
        check("t1 count", 32'(kb_if.count), 32'd3);
        check("t1 digits", kb_if.digits, 32'h0000_0321);
        check("t1 full", 32'(kb_if.full), 32'd0);
        idle();
        check("t1 no err", 32'(err_cnt), 32'd0);
        ev(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        check("t1 clr count", 32'(kb_if.count), 32'd0);
        check("t1 clr digits", kb_if.digits, 32'h0);

        // 2: fill to capacity then overflow
        for (int i = 0; i < 7; i++) key(4'(i));
        check("t2 full7", 32'(kb_if.full), 32'd0);
        key(4'h7);
        check("t2 full", 32'(kb_if.full), 32'd1);
        check("t2 count8", 32'(kb_if.count), 32'd8);
        check("t2 digits", kb_if.digits, 32'h7654_3210);
        key(4'h9);
        check("t2 ovf err", 32'(kb_if.err), 32'd1);
        check("t2 ovf code", 32'(kb_if.err_code), 32'd1);
        check("t2 ovf digits", kb_if.digits, 32'h7654_3210);
        check("t2 ovf count", 32'(kb_if.count), 32'd8);
        idle();
        check("t2 err pulse", 32'(kb_if.err), 32'd0);
        check("t2 code hold", 32'(kb_if.err_code), 32'd1);
        ev(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        check("t2 clr full", 32'(kb_if.full), 32'd0);
        check("t2 clr code kept", 32'(kb_if.err_code), 32'd1);

        // 3: underflow, then key and delete
        ev(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        check("t3 unf err", 32'(kb_if.err), 32'd1);
        check("t3 unf code", 32'(kb_if.err_code), 32'd2);
        check("t3 unf count", 32'(kb_if.count), 32'd0);
        key(4'h5);
        check("t3 key5", kb_if.digits, 32'h0000_0005);
        ev(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        check("t3 bs count", 32'(kb_if.count), 32'd0);
        check("t3 bs slot0", kb_if.digits, 32'h0);
        check("t3 bs no err", 32'(kb_if.err), 32'd0);

        // 4: confirm below and at the minimum
        key(4'h1);
        key(4'h2);
        key(4'h3);
        ev(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        check("t4 short err", 32'(kb_if.err), 32'd1);
        check("t4 short code", 32'(kb_if.err_code), 32'd3);
        check("t4 short locked", 32'(kb_if.locked), 32'd0);
        check("t4 short done", 32'(kb_if.done), 32'd0);
        key(4'h4);
        check("t4 digits", kb_if.digits, 32'h0000_4321);
        ev(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        check("t4 done", 32'(kb_if.done), 32'd1);
        check("t4 locked", 32'(kb_if.locked), 32'd1);
        check("t4 ok no err", 32'(kb_if.err), 32'd0);
        idle();
        check("t4 done pulse", 32'(kb_if.done), 32'd0);
        check("t4 locked hold", 32'(kb_if.locked), 32'd1);

        // 5: events ignored while locked
        err_base  = err_cnt;
        done_base = done_cnt;
        key(4'h7);
        ev(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        ev(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        idle();
        check("t5 digits", kb_if.digits, 32'h0000_4321);
        check("t5 count", 32'(kb_if.count), 32'd4);
        check("t5 no err", 32'(err_cnt - err_base), 32'd0);
        check("t5 no done", 32'(done_cnt - done_base), 32'd0);
        ev(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        check("t5 clr locked", 32'(kb_if.locked), 32'd0);
        check("t5 clr count", 32'(kb_if.count), 32'd0);
        check("t5 clr digits", kb_if.digits, 32'h0);

        // 6: priority and async reset
        key(4'h1);
        key(4'h2);
        ev(1'b1, 4'h9, 1'b1, 1'b0, 1'b0);
        check("t6 bs wins count", 32'(kb_if.count), 32'd1);
        check("t6 bs wins digits", kb_if.digits, 32'h0000_0001);
        key(4'h2);
        key(4'h3);
        key(4'h4);
        done_base = done_cnt;
        ev(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
        check("t6 clr wins count", 32'(kb_if.count), 32'd0);
        check("t6 clr wins locked", 32'(kb_if.locked), 32'd0);
        check("t6 clr wins done", 32'(kb_if.done), 32'd0);
        idle();
        check("t6 clr no done", 32'(done_cnt - done_base), 32'd0);
        key(4'h5);
        key(4'h6);
        key(4'h7);
        key(4'h8);
        ev(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        check("t6 pre locked", 32'(kb_if.locked), 32'd1);
        check("t6 pre code", 32'(kb_if.err_code), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("t6 arst digits", kb_if.digits, 32'h0);
        check("t6 arst count", 32'(kb_if.count), 32'd0);
        check("t6 arst locked", 32'(kb_if.locked), 32'd0);
        check("t6 arst done", 32'(kb_if.done), 32'd0);
        check("t6 arst code", 32'(kb_if.err_code), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        check("never err+done", 32'(both_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
